// File: rtl/mod_n_stream_detector_pkg.sv
// Shared types, parameter limits and width helper for the mod-N stream detector.
package mod_n_pkg;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  localparam int DIVISOR_MIN = 2;
  localparam int DIVISOR_MAX = 1024;
  localparam int DIN_W_MIN   = 1;
  localparam int DIN_W_MAX   = 16;

  function automatic int rem_width(input int divisor);
    return ($clog2(divisor) < 1) ? 1 : $clog2(divisor);
  endfunction

endpackage

// File: rtl/mod_n_stream_detector_if.sv
// Beat ingress and detector status bundle; master drives beats, slave is the detector.
interface mod_n_stream_detector_if
  import mod_n_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int DIN_W   = 1,
  parameter int CNT_W   = 16
);
  localparam int REM_W = rem_width(DIVISOR);

  logic             din_valid;
  logic [DIN_W-1:0] din;
  logic             clear;
  logic             dout;
  logic [REM_W-1:0] rem;
  logic             dout_valid;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output din_valid, din, clear,
    input  dout, rem, dout_valid, beat_cnt
  );

  modport slave (
    input  din_valid, din, clear,
    output dout, rem, dout_valid, beat_cnt
  );
endinterface

// File: rtl/mod_n_stream_detector_step.sv
// One beat of remainder update: r = (2r + b) mod DIVISOR per bit, MSB first.
module mod_n_step
  import mod_n_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int DIN_W   = 1
) (
  input  logic [rem_width(DIVISOR)-1:0] rem_in,
  input  logic [DIN_W-1:0]              din,
  output logic [rem_width(DIVISOR)-1:0] rem_out
);
  localparam int REM_W = rem_width(DIVISOR);
  localparam logic [REM_W:0] DIV_V = (REM_W+1)'(DIVISOR);

  logic [REM_W:0]   t;
  logic [REM_W-1:0] r;

  // 2r+b < 2*DIVISOR, so a single conditional subtract restores the range
  always_comb begin
    r = rem_in;
    t = '0;
    for (int i = DIN_W - 1; i >= 0; i--) begin
      t = {r, din[i]};
      if (t >= DIV_V) t = t - DIV_V;
      r = t[REM_W-1:0];
    end
    rem_out = r;
  end
endmodule

// File: rtl/mod_n_stream_detector.sv
// Divisibility detector for an MSB-first stream arriving DIN_W bits per valid beat.
//   state    | meaning
//   S_IDLE   | no beat accepted since reset/clear; dout forced low
//   S_ACTIVE | at least one beat accepted; dout = (rem == 0)
module mod_n_stream_detector
  import mod_n_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int DIN_W   = 1,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               reset,
  mod_n_stream_detector_if.slave bus
);
  localparam int REM_W = rem_width(DIVISOR);

  if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX ||
      DIN_W < DIN_W_MIN || DIN_W > DIN_W_MAX || CNT_W < 1) begin : g_bad_param
    $error("mod_n_stream_detector: DIVISOR/DIN_W/CNT_W out of legal range");
  end

  state_t           state_q, state_nxt;
  logic [REM_W-1:0] rem_q, rem_nxt, base, rem_step;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             dout_q, dout_nxt;
  logic             dvalid_q, dvalid_nxt;

  // clear alongside a beat restarts the stream from that beat
  assign base = (state_q == S_IDLE || bus.clear) ? '0 : rem_q;

  mod_n_step #(.DIVISOR(DIVISOR), .DIN_W(DIN_W)) u_step (
    .rem_in  (base),
    .din     (bus.din),
    .rem_out (rem_step)
  );

  always_comb begin
    state_nxt  = state_q;
    rem_nxt    = rem_q;
    cnt_nxt    = cnt_q;
    dvalid_nxt = 1'b0;
    if (bus.din_valid) begin
      state_nxt  = S_ACTIVE;
      rem_nxt    = rem_step;
      dvalid_nxt = 1'b1;
      if (bus.clear)                 cnt_nxt = CNT_W'(1);
      else if (cnt_q != {CNT_W{1'b1}}) cnt_nxt = cnt_q + CNT_W'(1);
    end else if (bus.clear) begin
      state_nxt = S_IDLE;
      rem_nxt   = '0;
      cnt_nxt   = '0;
    end
    dout_nxt = (state_nxt == S_ACTIVE) && (rem_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      rem_q    <= rem_nxt;
      cnt_q    <= cnt_nxt;
      dout_q   <= dout_nxt;
      dvalid_q <= dvalid_nxt;
    end
  end

  assign bus.rem        = rem_q;
  assign bus.beat_cnt   = cnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dvalid_q;
endmodule

// File: tb/tb_mod_n_stream_detector.sv
// Six detector configurations driven in parallel, checked against an arithmetic mod model.
module tb_mod_n_stream_detector;
  localparam int NI = 6;
  localparam int DV [NI] = '{3, 5, 7, 4, 10, 13};
  localparam int W  [NI] = '{1, 4, 1, 2, 3, 8};
  localparam int CW [NI] = '{16, 16, 16, 2, 16, 16};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        v [NI];
  logic        c [NI];
  logic [15:0] d [NI];
  logic [31:0] o_rem [NI];
  logic [31:0] o_cnt [NI];
  logic        o_dout [NI];
  logic        o_dv [NI];

  int total = 0;
  int bad   = 0;

  bit m_act [NI];
  int m_rem [NI];
  int m_cnt [NI];
  bit m_dv  [NI];

  mod_n_stream_detector_if #(.DIVISOR(DV[0]), .DIN_W(W[0]), .CNT_W(CW[0])) if0 ();
  mod_n_stream_detector_if #(.DIVISOR(DV[1]), .DIN_W(W[1]), .CNT_W(CW[1])) if1 ();
  mod_n_stream_detector_if #(.DIVISOR(DV[2]), .DIN_W(W[2]), .CNT_W(CW[2])) if2 ();
  mod_n_stream_detector_if #(.DIVISOR(DV[3]), .DIN_W(W[3]), .CNT_W(CW[3])) if3 ();
  mod_n_stream_detector_if #(.DIVISOR(DV[4]), .DIN_W(W[4]), .CNT_W(CW[4])) if4 ();
  mod_n_stream_detector_if #(.DIVISOR(DV[5]), .DIN_W(W[5]), .CNT_W(CW[5])) if5 ();

  mod_n_stream_detector #(.DIVISOR(DV[0]), .DIN_W(W[0]), .CNT_W(CW[0])) u0 (.clk(clk), .reset(reset), .bus(if0));
  mod_n_stream_detector #(.DIVISOR(DV[1]), .DIN_W(W[1]), .CNT_W(CW[1])) u1 (.clk(clk), .reset(reset), .bus(if1));
  mod_n_stream_detector #(.DIVISOR(DV[2]), .DIN_W(W[2]), .CNT_W(CW[2])) u2 (.clk(clk), .reset(reset), .bus(if2));
  mod_n_stream_detector #(.DIVISOR(DV[3]), .DIN_W(W[3]), .CNT_W(CW[3])) u3 (.clk(clk), .reset(reset), .bus(if3));
  mod_n_stream_detector #(.DIVISOR(DV[4]), .DIN_W(W[4]), .CNT_W(CW[4])) u4 (.clk(clk), .reset(reset), .bus(if4));
  mod_n_stream_detector #(.DIVISOR(DV[5]), .DIN_W(W[5]), .CNT_W(CW[5])) u5 (.clk(clk), .reset(reset), .bus(if5));

  assign if0.din_valid = v[0]; assign if0.clear = c[0]; assign if0.din = d[0][0:0];
  assign if1.din_valid = v[1]; assign if1.clear = c[1]; assign if1.din = d[1][3:0];
  assign if2.din_valid = v[2]; assign if2.clear = c[2]; assign if2.din = d[2][0:0];
  assign if3.din_valid = v[3]; assign if3.clear = c[3]; assign if3.din = d[3][1:0];
  assign if4.din_valid = v[4]; assign if4.clear = c[4]; assign if4.din = d[4][2:0];
  assign if5.din_valid = v[5]; assign if5.clear = c[5]; assign if5.din = d[5][7:0];

  assign o_rem[0] = 32'(if0.rem); assign o_cnt[0] = 32'(if0.beat_cnt);
  assign o_rem[1] = 32'(if1.rem); assign o_cnt[1] = 32'(if1.beat_cnt);
  assign o_rem[2] = 32'(if2.rem); assign o_cnt[2] = 32'(if2.beat_cnt);
  assign o_rem[3] = 32'(if3.rem); assign o_cnt[3] = 32'(if3.beat_cnt);
  assign o_rem[4] = 32'(if4.rem); assign o_cnt[4] = 32'(if4.beat_cnt);
  assign o_rem[5] = 32'(if5.rem); assign o_cnt[5] = 32'(if5.beat_cnt);
  assign o_dout[0] = if0.dout; assign o_dv[0] = if0.dout_valid;
  assign o_dout[1] = if1.dout; assign o_dv[1] = if1.dout_valid;
  assign o_dout[2] = if2.dout; assign o_dv[2] = if2.dout_valid;
  assign o_dout[3] = if3.dout; assign o_dv[3] = if3.dout_valid;
  assign o_dout[4] = if4.dout; assign o_dv[4] = if4.dout_valid;
  assign o_dout[5] = if5.dout; assign o_dv[5] = if5.dout_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model tracks the stream value modulo DIVISOR: value' = value * 2^W + din.
  task automatic cycle();
    int base;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        m_act[k] = 0; m_rem[k] = 0; m_cnt[k] = 0; m_dv[k] = 0;
      end else if (v[k]) begin
        base = (!m_act[k] || c[k]) ? 0 : m_rem[k];
        m_rem[k] = (base * (1 << W[k]) + int'(d[k] & 16'((1 << W[k]) - 1))) % DV[k];
        m_cnt[k] = c[k] ? 1 : ((m_cnt[k] + 1 > (1 << CW[k]) - 1) ? m_cnt[k] : m_cnt[k] + 1);
        m_act[k] = 1;
        m_dv[k]  = 1;
      end else begin
        m_dv[k] = 0;
        if (c[k]) begin
          m_act[k] = 0; m_rem[k] = 0; m_cnt[k] = 0;
        end
      end
      chk($sformatf("model_rem_i%0d", k),  o_rem[k], m_rem[k]);
      chk($sformatf("model_cnt_i%0d", k),  o_cnt[k], m_cnt[k]);
      chk($sformatf("model_dout_i%0d", k), 32'(o_dout[k]), 32'(m_act[k] && m_rem[k] == 0));
      chk($sformatf("model_dv_i%0d", k),   32'(o_dv[k]), 32'(m_dv[k]));
    end
  endtask

  task automatic dbeat(input int k, input logic vv, input logic cc, input logic [15:0] dd,
                       input int er, input int ed, input int edv, input int ec, input string tag);
    v[k] = vv; c[k] = cc; d[k] = dd;
    cycle();
    chk({tag, "_rem"},  o_rem[k], er);
    chk({tag, "_dout"}, 32'(o_dout[k]), ed);
    chk({tag, "_dv"},   32'(o_dv[k]), edv);
    chk({tag, "_cnt"},  o_cnt[k], ec);
    v[k] = 1'b0; c[k] = 1'b0; d[k] = '0;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      v[k] = 1'b0; c[k] = 1'b0; d[k] = '0;
    end
    reset = 1'b1;
    cycle();
    cycle();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_rem_i%0d", k), o_rem[k], 0);
      chk($sformatf("reset_dout_i%0d", k), 32'(o_dout[k]), 0);
      chk($sformatf("reset_dv_i%0d", k), 32'(o_dv[k]), 0);
      chk($sformatf("reset_cnt_i%0d", k), o_cnt[k], 0);
    end
    reset = 1'b0;

    // div 3, 1-bit beats: 1,1,0 = 6
    dbeat(0, 1, 0, 16'd1, 1, 0, 1, 1, "d3_b1");
    dbeat(0, 1, 0, 16'd1, 0, 1, 1, 2, "d3_b2");
    dbeat(0, 1, 0, 16'd0, 0, 1, 1, 3, "d3_b3");
    for (int i = 0; i < 4; i++)
      dbeat(0, 0, 0, (i % 2 == 1) ? 16'bx : 16'(i), 0, 1, 0, 3, $sformatf("d3_hold%0d", i));

    // div 5, 4-bit beats: 0x1, 0x4 (20), 0x3 (323)
    dbeat(1, 1, 0, 16'h1, 1, 0, 1, 1, "d5_b1");
    dbeat(1, 1, 0, 16'h4, 0, 1, 1, 2, "d5_b2");
    dbeat(1, 1, 0, 16'h3, 3, 0, 1, 3, "d5_b3");

    // div 7: 111 = 7, then restart with a beat, then clear alone
    dbeat(2, 1, 0, 16'd1, 1, 0, 1, 1, "d7_b1");
    dbeat(2, 1, 0, 16'd1, 3, 0, 1, 2, "d7_b2");
    dbeat(2, 1, 0, 16'd1, 0, 1, 1, 3, "d7_b3");
    dbeat(2, 1, 1, 16'd1, 1, 0, 1, 1, "d7_clr_valid");
    dbeat(2, 0, 1, 16'd1, 0, 0, 0, 0, "d7_clr_alone");

    // div 4, 2-bit beats, 2-bit counter saturates
    for (int i = 0; i < 5; i++)
      dbeat(3, 1, 0, 16'h3, 3, 0, 1, (i < 3) ? i + 1 : 3, $sformatf("d4_sat%0d", i));

    // reset mid-stream wins over a valid beat; first zero beat afterwards is divisible
    reset = 1'b1;
    dbeat(0, 1, 0, 16'd1, 0, 0, 0, 0, "rst_mid");
    reset = 1'b0;
    dbeat(0, 1, 0, 16'd0, 0, 1, 1, 1, "rst_first0");

    for (int n = 0; n < 12000; n++) begin
      reset = ($urandom_range(0, 999) == 0);
      for (int k = 0; k < NI; k++) begin
        v[k] = ($urandom_range(0, 3) != 0);
        c[k] = ($urandom_range(0, 19) == 0);
        d[k] = 16'($urandom);
      end
      cycle();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
